// File: rtl/clause_stream_if.sv
// Chunk-in / result-out handshake bundle for the clause stream evaluator.
// The master side feeds clause chunks and consumes results; the slave side is the evaluator.
interface clause_stream_if #(
  parameter int VAR_PER_CLAUSE = 5,
  parameter int MAX_VARS_BITS  = 8
);
  // Chunk channel
  logic                                             in_valid;
  logic                                             in_ready;
  logic                                             in_last;
  logic [VAR_PER_CLAUSE-1:0]                        unassign;
  logic [VAR_PER_CLAUSE-1:0]                        clause_mask;
  logic [VAR_PER_CLAUSE-1:0]                        clause_pole;
  logic [VAR_PER_CLAUSE-1:0]                        val;
  logic [VAR_PER_CLAUSE-1:0][MAX_VARS_BITS-1:0]     variable;

  // Result channel
  logic                                             out_valid;
  logic                                             out_ready;
  logic [1:0]                                       status;
  logic [MAX_VARS_BITS-1:0]                         implied_variable;
  logic                                             new_val;
  logic                                             overflow;

  modport master (
    output in_valid, in_last, unassign, clause_mask, clause_pole, val, variable, out_ready,
    input  in_ready, out_valid, status, implied_variable, new_val, overflow
  );

  modport slave (
    input  in_valid, in_last, unassign, clause_mask, clause_pole, val, variable, out_ready,
    output in_ready, out_valid, status, implied_variable, new_val, overflow
  );
endinterface

// File: rtl/clause_stream_evaluator.sv
// Streaming CNF clause evaluator. A clause arrives as one or more chunks of
// VAR_PER_CLAUSE literals; after the final chunk the clause is classified as
// unresolved, unit (with the forced variable/value), satisfied or conflicting.
// A clause that runs to MAX_CHUNKS without in_last is cut off and flagged.
module clause_stream_evaluator #(
  parameter int VAR_PER_CLAUSE = 5,
  parameter int MAX_VARS_BITS  = 8,
  parameter int MAX_CHUNKS     = 4
) (
  input  logic           clock,
  input  logic           reset,
  clause_stream_if.slave bus
);

  localparam int W     = VAR_PER_CLAUSE;
  localparam int VB    = MAX_VARS_BITS;
  localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

  localparam logic [1:0] ST_UNRESOLVED = 2'b00;
  localparam logic [1:0] ST_UNIT       = 2'b01;
  localparam logic [1:0] ST_SATISFIED  = 2'b10;
  localparam logic [1:0] ST_CONFLICT   = 2'b11;

  typedef enum logic {ACCUM, RESULT} state_t;

  // Number of set bits, clamped at 2 (only 0 / 1 / many matters for a clause).
  function automatic logic [1:0] sat_popcount(input logic [W-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) begin
      c = c + int'(v[i]);
    end
    return (c >= 2) ? 2'd2 : 2'(c);
  endfunction

  // Two-bit add clamped at 2.
  function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd2) ? 2'd2 : s[1:0];
  endfunction

  // Satisfaction dominates; otherwise the number of open literals decides.
  function automatic logic [1:0] resolve_status(input logic sat, input logic [1:0] open_n);
    logic [1:0] st;
    if (sat)                st = ST_SATISFIED;
    else if (open_n == 2'd0) st = ST_CONFLICT;
    else if (open_n == 2'd1) st = ST_UNIT;
    else                     st = ST_UNRESOLVED;
    return st;
  endfunction

  state_t state;

  // Clause accumulators (stage 0)
  logic             sat_acc_p0;
  logic [1:0]       open_cnt_p0;
  logic [CNT_W-1:0] chunk_cnt_p0;
  logic             cap_vld_p0;
  logic [VB-1:0]    cap_var_p0;
  logic             cap_pole_p0;

  // Registered result (stage 1)
  logic [1:0]       status_p1;
  logic [VB-1:0]    implied_p1;
  logic             new_val_p1;
  logic             overflow_p1;

  // Per-chunk literal classification
  logic [W-1:0]     lit_true;
  logic [W-1:0]     lit_open;
  logic             first_hit;
  logic [VB-1:0]    first_var;
  logic             first_pole;

  // Next-accumulator values for the chunk currently presented
  logic             accept;
  logic             final_chunk;
  logic             sat_nxt;
  logic [1:0]       open_nxt;
  logic             cap_vld_nxt;
  logic [VB-1:0]    cap_var_nxt;
  logic             cap_pole_nxt;
  logic [1:0]       status_nxt;

  // Classify each literal of the presented chunk as true and/or open.
  always_comb begin
    lit_true = '0;
    lit_open = '0;
    for (int i = 0; i < W; i++) begin
      lit_true[i] = bus.clause_mask[i] && !bus.unassign[i] && (bus.val[i] ^ bus.clause_pole[i]);
      lit_open[i] = bus.clause_mask[i] && bus.unassign[i];
    end
  end

  // Pick the lowest-index open literal of the chunk (descending scan, last hit wins).
  always_comb begin
    first_hit  = 1'b0;
    first_var  = '0;
    first_pole = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (lit_open[i]) begin
        first_hit  = 1'b1;
        first_var  = bus.variable[i];
        first_pole = bus.clause_pole[i];
      end
    end
  end

  // Fold the presented chunk into the running clause summary.
  always_comb begin
    accept       = bus.in_valid && (state == ACCUM);
    final_chunk  = bus.in_last || (chunk_cnt_p0 == CNT_W'(MAX_CHUNKS - 1));
    sat_nxt      = sat_acc_p0 | (|lit_true);
    open_nxt     = sat_add2(open_cnt_p0, sat_popcount(lit_open));
    cap_vld_nxt  = cap_vld_p0 | first_hit;
    cap_var_nxt  = cap_vld_p0 ? cap_var_p0  : first_var;
    cap_pole_nxt = cap_vld_p0 ? cap_pole_p0 : first_pole;
    status_nxt   = resolve_status(sat_nxt, open_nxt);
  end

  // Control FSM: accumulate chunks, then hold the registered result until consumed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ACCUM;
      sat_acc_p0   <= 1'b0;
      open_cnt_p0  <= 2'd0;
      chunk_cnt_p0 <= '0;
      cap_vld_p0   <= 1'b0;
      cap_var_p0   <= '0;
      cap_pole_p0  <= 1'b0;
      status_p1    <= ST_UNRESOLVED;
      implied_p1   <= '0;
      new_val_p1   <= 1'b0;
      overflow_p1  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (final_chunk) begin
              state       <= RESULT;
              status_p1   <= status_nxt;
              implied_p1  <= (status_nxt == ST_UNIT) ? cap_var_nxt : '0;
              new_val_p1  <= (status_nxt == ST_UNIT) && !cap_pole_nxt;
              // Reaching the final chunk without in_last means the chunk limit cut it off.
              overflow_p1 <= !bus.in_last;
            end else begin
              sat_acc_p0   <= sat_nxt;
              open_cnt_p0  <= open_nxt;
              chunk_cnt_p0 <= chunk_cnt_p0 + CNT_W'(1);
              cap_vld_p0   <= cap_vld_nxt;
              cap_var_p0   <= cap_var_nxt;
              cap_pole_p0  <= cap_pole_nxt;
            end
          end
        end
        RESULT: begin
          if (bus.out_ready) begin
            state        <= ACCUM;
            sat_acc_p0   <= 1'b0;
            open_cnt_p0  <= 2'd0;
            chunk_cnt_p0 <= '0;
            cap_vld_p0   <= 1'b0;
            cap_var_p0   <= '0;
            cap_pole_p0  <= 1'b0;
            status_p1    <= ST_UNRESOLVED;
            implied_p1   <= '0;
            new_val_p1   <= 1'b0;
            overflow_p1  <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready         = (state == ACCUM);
  assign bus.out_valid        = (state == RESULT);
  assign bus.status           = status_p1;
  assign bus.implied_variable = implied_p1;
  assign bus.new_val          = new_val_p1;
  assign bus.overflow         = overflow_p1;

endmodule

// File: tb/tb_clause_stream_evaluator.sv
// Directed bench for clause_stream_evaluator (W=5, 8-bit variable index, 4 chunks max).
// Observed vector layout: {out_valid, in_ready, status[1:0], implied_variable[7:0], new_val, overflow}.
module tb_clause_stream_evaluator;
  localparam int W  = 5;
  localparam int VB = 8;
  localparam int MC = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  clause_stream_if #(.VAR_PER_CLAUSE(W), .MAX_VARS_BITS(VB)) bus ();

  clause_stream_evaluator #(
    .VAR_PER_CLAUSE(W),
    .MAX_VARS_BITS (VB),
    .MAX_CHUNKS    (MC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [13:0] obs;
  assign obs = {bus.out_valid, bus.in_ready, bus.status, bus.implied_variable, bus.new_val, bus.overflow};

  localparam logic [13:0] IDLE_VEC = {1'b0, 1'b1, 2'b00, 8'd0, 1'b0, 1'b0};

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_last     = 1'b0;
    bus.unassign    = '0;
    bus.clause_mask = '0;
    bus.clause_pole = '0;
    bus.val         = '0;
    bus.variable    = '0;
    bus.out_ready   = 1'b0;
  endtask

  // Present one chunk and hold it until accepted (called at posedge+1).
  task automatic drive_chunk(input logic [W-1:0] ua, input logic [W-1:0] mask,
                             input logic [W-1:0] pole, input logic [W-1:0] value,
                             input logic [W-1:0][VB-1:0] vars, input logic last);
    int n;
    n = 0;
    bus.unassign    = ua;
    bus.clause_mask = mask;
    bus.clause_pole = pole;
    bus.val         = value;
    bus.variable    = vars;
    bus.in_last     = last;
    bus.in_valid    = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got %b want 1", bus.in_ready);
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0][VB-1:0] v;
    v = '0;
    reset = 1'b0;
    bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.clause_mask = 5'b11111; bus.unassign = 5'b10000;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (obs !== IDLE_VEC) begin errors++; $display("FAIL reset_state got %h want %h", obs, IDLE_VEC); end
    idle_inputs();
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (obs !== IDLE_VEC) begin errors++; $display("FAIL reset_release got %h want %h", obs, IDLE_VEC); end
  endtask

  task automatic test_unit_single();
    logic [W-1:0][VB-1:0] v;
    logic [13:0] exp_v;
    v = '0; v[4] = 8'd17;
    drive_chunk(5'b10000, 5'b11111, 5'b00000, 5'b00000, v, 1'b1);
    exp_v = {1'b1, 1'b0, 2'b01, 8'd17, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL unit_single got %h want %h", obs, exp_v); end
    consume();
    checks++;
    if (obs[13:12] !== 2'b01) begin errors++; $display("FAIL unit_single_release got %b want 01", obs[13:12]); end
  endtask

  task automatic test_unit_two_chunk();
    logic [W-1:0][VB-1:0] v;
    logic [13:0] exp_v;
    v = '0;
    drive_chunk(5'b00000, 5'b11111, 5'b00000, 5'b00000, v, 1'b0);
    v[2] = 8'd9;
    drive_chunk(5'b00100, 5'b11111, 5'b00100, 5'b00000, v, 1'b1);
    exp_v = {1'b1, 1'b0, 2'b01, 8'd9, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL unit_two_chunk got %h want %h", obs, exp_v); end
    consume();
  endtask

  task automatic test_sat_dominates();
    logic [W-1:0][VB-1:0] v;
    logic [13:0] exp_v;
    v = '0; v[0] = 8'd33;
    drive_chunk(5'b00001, 5'b11111, 5'b00000, 5'b00000, v, 1'b0);
    drive_chunk(5'b00000, 5'b11111, 5'b00000, 5'b00010, v, 1'b1);
    exp_v = {1'b1, 1'b0, 2'b10, 8'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL sat_dominates got %h want %h", obs, exp_v); end
    consume();
  endtask

  task automatic test_conflict_unresolved();
    logic [W-1:0][VB-1:0] v;
    logic [13:0] exp_v;
    v = '0; v[0] = 8'd1; v[1] = 8'd2; v[2] = 8'd3; v[3] = 8'd4; v[4] = 8'd5;
    drive_chunk(5'b00000, 5'b11111, 5'b00000, 5'b00000, v, 1'b0);
    drive_chunk(5'b00000, 5'b11111, 5'b11111, 5'b11111, v, 1'b0);
    drive_chunk(5'b00000, 5'b11111, 5'b00000, 5'b00000, v, 1'b1);
    exp_v = {1'b1, 1'b0, 2'b11, 8'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL conflict got %h want %h", obs, exp_v); end
    consume();
    drive_chunk(5'b11111, 5'b11111, 5'b00000, 5'b00000, v, 1'b1);
    exp_v = {1'b1, 1'b0, 2'b00, 8'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL unresolved got %h want %h", obs, exp_v); end
    consume();
  endtask

  task automatic test_mask_polarity();
    logic [W-1:0][VB-1:0] v;
    logic [13:0] exp_v;
    // Fully masked chunk: would look open/true if the mask were ignored.
    v = '0; v[0] = 8'd99; v[1] = 8'd98; v[2] = 8'd97;
    drive_chunk(5'b00011, 5'b00000, 5'b00000, 5'b11100, v, 1'b0);
    v = '0; v[1] = 8'd5;
    drive_chunk(5'b00010, 5'b11111, 5'b00000, 5'b00000, v, 1'b1);
    exp_v = {1'b1, 1'b0, 2'b01, 8'd5, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mask_zero_chunk got %h want %h", obs, exp_v); end
    consume();
    // Negated literal with value 0 is true.
    v = '0;
    drive_chunk(5'b00000, 5'b00001, 5'b00001, 5'b00000, v, 1'b1);
    exp_v = {1'b1, 1'b0, 2'b10, 8'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL negated_true got %h want %h", obs, exp_v); end
    consume();
    // True-looking literals outside the mask are ignored.
    drive_chunk(5'b00000, 5'b00001, 5'b00000, 5'b11110, v, 1'b1);
    exp_v = {1'b1, 1'b0, 2'b11, 8'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL unmasked_ignored got %h want %h", obs, exp_v); end
    consume();
  endtask

  task automatic test_overflow();
    logic [W-1:0][VB-1:0] v;
    logic [13:0] exp_v;
    v = '0;
    drive_chunk(5'b00000, 5'b11111, 5'b00000, 5'b00000, v, 1'b0);
    drive_chunk(5'b00000, 5'b11111, 5'b00000, 5'b00000, v, 1'b0);
    v[3] = 8'd77;
    drive_chunk(5'b01000, 5'b11111, 5'b01000, 5'b00000, v, 1'b0);
    checks++;
    if (obs[13:12] !== 2'b01) begin errors++; $display("FAIL overflow_early got %b want 01", obs[13:12]); end
    v = '0;
    drive_chunk(5'b00000, 5'b11111, 5'b00000, 5'b00000, v, 1'b0);
    exp_v = {1'b1, 1'b0, 2'b01, 8'd77, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL overflow got %h want %h", obs, exp_v); end
    @(posedge clock); #1;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL overflow_hold got %h want %h", obs, exp_v); end
    consume();
    // in_last exactly on the last allowed chunk is not an overflow.
    for (int k = 0; k < MC; k++) begin
      drive_chunk(5'b00000, 5'b11111, 5'b00000, 5'b00000, v, (k == MC - 1));
    end
    exp_v = {1'b1, 1'b0, 2'b11, 8'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL last_at_max got %h want %h", obs, exp_v); end
    consume();
  endtask

  task automatic test_backpressure();
    logic [W-1:0][VB-1:0] v;
    logic [13:0] exp_v;
    v = '0; v[2] = 8'd200;
    drive_chunk(5'b00100, 5'b11111, 5'b00000, 5'b00000, v, 1'b1);
    exp_v = {1'b1, 1'b0, 2'b01, 8'd200, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL hold_cycle%0d got %h want %h", k, obs, exp_v); end
      @(posedge clock); #1;
    end
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hold_final got %h want %h", obs, exp_v); end
    consume();
    checks++;
    if (obs[13:12] !== 2'b01) begin errors++; $display("FAIL post_handshake got %b want 01", obs[13:12]); end
  endtask

  task automatic test_ignore_unaccepted();
    logic [W-1:0][VB-1:0] v;
    logic [13:0] exp_v;
    v = '0; v[0] = 8'd11;
    bus.in_valid = 1'b0; bus.in_last = 1'b1; bus.unassign = 5'b00001;
    bus.clause_mask = 5'b11111; bus.variable = v;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (obs !== IDLE_VEC) begin errors++; $display("FAIL ignore_invalid got %h want %h", obs, IDLE_VEC); end
    v = '0;
    drive_chunk(5'b00000, 5'b11111, 5'b00000, 5'b00000, v, 1'b1);
    exp_v = {1'b1, 1'b0, 2'b11, 8'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ignore_then_clause got %h want %h", obs, exp_v); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0][VB-1:0] v;
    logic [13:0] exp_v;
    v = '0;
    drive_chunk(5'b00000, 5'b11111, 5'b00000, 5'b00000, v, 1'b1);
    // Offer the next clause in the same cycle as the handshake.
    v[3] = 8'd40;
    bus.unassign = 5'b01000; bus.clause_mask = 5'b11111; bus.clause_pole = 5'b00000;
    bus.val = 5'b00000; bus.variable = v; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (obs[13:12] !== 2'b01) begin errors++; $display("FAIL no_same_cycle_accept got %b want 01", obs[13:12]); end
    @(posedge clock); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    exp_v = {1'b1, 1'b0, 2'b01, 8'd40, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL back_to_back got %h want %h", obs, exp_v); end
    consume();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0][VB-1:0] v;
    logic [13:0] exp_v;
    v = '0; v[0] = 8'd50;
    drive_chunk(5'b00001, 5'b11111, 5'b00000, 5'b00000, v, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (obs !== IDLE_VEC) begin errors++; $display("FAIL reset_mid_clause got %h want %h", obs, IDLE_VEC); end
    v = '0; v[1] = 8'd3;
    drive_chunk(5'b00010, 5'b11111, 5'b00000, 5'b00000, v, 1'b1);
    exp_v = {1'b1, 1'b0, 2'b01, 8'd3, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL clean_after_reset got %h want %h", obs, exp_v); end
    // Reset while a result is pending drops it.
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    checks++;
    if (obs !== IDLE_VEC) begin errors++; $display("FAIL reset_in_result got %h want %h", obs, IDLE_VEC); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_unit_single();
    test_unit_two_chunk();
    test_sat_dominates();
    test_conflict_unresolved();
    test_mask_polarity();
    test_overflow();
    test_backpressure();
    test_ignore_unaccepted();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clause_stream_evaluator.md
CLAUSE_STREAM_EVALUATOR -- requirements
Module: clause_stream_evaluator

Interface
- REQ-001 SHALL expose parameter VAR_PER_CLAUSE, default 5, literals per chunk (W).
- REQ-002 SHALL expose parameter MAX_VARS_BITS, default 8, variable index width.
- REQ-003 SHALL expose parameter MAX_CHUNKS, default 4, max chunks per clause.
- REQ-004 clock  in  1  single clock; all state updates on rising edge.
- REQ-005 reset  in  1  synchronous, active-low reset; sampled on rising clock edge.
- REQ-006 in_valid  in  1  chunk presented.
- REQ-007 in_ready  out  1  chunk accepted when in_valid && in_ready.
- REQ-008 in_last  in  1  final chunk of current clause.
- REQ-009 unassign, clause_mask, clause_pole, val  in  W each  per-literal unassigned flag, literal present, polarity (1 = negated), assigned value.
- REQ-010 variable  in  W x MAX_VARS_BITS  per-literal variable index.
- REQ-011 out_valid  out  1  result available.
- REQ-012 out_ready  in  1  result consumed when out_valid && out_ready.
- REQ-013 status  out  2  00 unresolved, 01 unit, 10 satisfied, 11 conflict.
- REQ-014 implied_variable  out  MAX_VARS_BITS  variable forced by unit clause.
- REQ-015 new_val  out  1  value forced on implied_variable.
- REQ-016 overflow  out  1  clause exceeded MAX_CHUNKS without in_last.

Function
- REQ-017 Literal i active iff clause_mask[i]; true iff active && !unassign[i] && (val[i] ^ clause_pole[i]); open iff active && unassign[i].
- REQ-018 FSM states ACCUM and RESULT; in_ready = (state == ACCUM); out_valid = (state == RESULT).
- REQ-019 Per accepted chunk: sat_acc |= any true literal; open_cnt += popcount(open), saturating at 2; chunk_cnt += 1.
- REQ-020 First open literal (lowest chunk, then lowest index) SHALL be captured into implied_variable, with new_val = ~clause_pole of that literal; later open literals SHALL NOT overwrite it.
- REQ-021 Accepted chunk with in_last=1, or accepted chunk making chunk_cnt == MAX_CHUNKS, SHALL move ACCUM->RESULT; result visible the next cycle (latency 1 cycle after final chunk).
- REQ-022 Forced termination at MAX_CHUNKS with in_last=0 SHALL set overflow=1; otherwise overflow=0.
- REQ-023 status: sat_acc -> 10; else open_cnt==0 -> 11; else open_cnt==1 -> 01; else 00; satisfaction dominates open count.
- REQ-024 implied_variable/new_val meaningful only when status==01; otherwise SHALL be 0.
- REQ-025 status, implied_variable, new_val, overflow SHALL hold stable while out_valid && !out_ready.
- REQ-026 On out_valid && out_ready: RESULT->ACCUM, clear all accumulators; in_ready high the following cycle (no same-cycle accept of next chunk).
- REQ-027 Chunk with clause_mask == 0 SHALL count toward chunk_cnt but contribute nothing else.
- REQ-028 Inputs other than in_valid/out_ready SHALL be ignored when not accepted.

Reset
- REQ-029 reset==0 at a clock edge SHALL force state ACCUM, accumulators 0, out_valid=0, status=00, implied_variable=0, new_val=0, overflow=0, in_ready=1 next cycle.
- REQ-030 Reset mid-clause or in RESULT SHALL discard the partial clause/pending result; no result emitted for it.

Verification
- REQ-031 Single chunk, unassign=10000, mask=11111, pole=00000, val=00000, variable[4]=17, in_last=1 -> next cycle status=01, implied_variable=17, new_val=1.
- REQ-032 Two chunks: chunk0 all assigned false (unassign=00000, mask=11111, pole=0, val=0), chunk1 unassign=00100, pole=00100, variable[2]=9, in_last -> status=01, implied_variable=9, new_val=0.
- REQ-033 Chunk0 unassign=00001 (open), chunk1 val=00010 mask=11111 pole=0 unassign=0, in_last -> status=10, implied_variable=0.
- REQ-034 All literals assigned false across 3 chunks -> status=11; unassign=11111 in one chunk -> status=00.
- REQ-035 4 chunks with in_last=0 (MAX_CHUNKS=4) -> after 4th accept, out_valid=1, overflow=1, in_ready=0 until out_ready.
- REQ-036 out_ready=0 for 3 cycles then 1 -> outputs stable 3 cycles, in_ready=1 cycle after handshake; reset=0 mid-clause -> no out_valid, subsequent clause evaluates from clean state.
